sw_array_ctrl: RTL and testbench
================================

Name: sw_array_ctrl

Overview:
Sequencer for a linear systolic array of N_PE Smith-Waterman processing elements. It clears the array, loads one query base per PE, and latches the scoring configuration. It then streams target bases into PE 0 as a gap-free burst, waits for the last PE's valid flag, and returns the unbiased best local-alignment score. It sits between the host/DMA stream interfaces and the array instance.

Parameters:
N_PE, 8, number of PEs in the array; maximum query length
SCORE_WIDTH, 12, score width in bits; biased zero ZERO = 2**(SCORE_WIDTH-1)
QLEN_W, clog2(N_PE+1), width of the q_len field
DRAIN_MAX, 2*N_PE+4, DRAIN cycle limit before a timeout error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  job request; sampled only in IDLE
q_len  in  QLEN_W  query length, legal 1..N_PE; sampled with start
cfg_match/cfg_mismatch/cfg_gap_open/cfg_gap_extend  in  SCORE_WIDTH each  scoring values; sampled with start
q_valid  in  1  query base valid
q_base  in  2  query base (A=00 G=01 T=10 C=11)
q_ready  out  1  query base accepted when q_valid&q_ready
t_valid  in  1  target base valid
t_base  in  2  target base
t_last  in  1  marks final target base
t_ready  out  1  target base accepted when t_valid&t_ready
arr_rst  out  1  active-low reset to all PEs
pe_q_we  out  1  query register write strobe
pe_q_idx  out  clog2(N_PE)  destination PE index
pe_q_base  out  2  query base to write
arr_match/arr_mismatch/arr_gap_open/arr_gap_extend  out  SCORE_WIDTH each  latched configuration, stable while busy
arr_en  out  1  enable into PE 0
arr_data  out  2  target base into PE 0
arr_high  in  SCORE_WIDTH  High_out of the last PE (biased)
arr_vld  in  1  vld of the last PE
busy  out  1  high in every state except IDLE
score  out  SCORE_WIDTH-1  arr_high - ZERO, held until the next score_valid
score_valid  out  1  one-cycle pulse in DONE
err  out  1  one-cycle error pulse
err_code  out  2  1 = bad q_len, 2 = stream gap, 3 = drain timeout; held until the next err

Behaviour:
- All outputs are registered. Reset values: state=IDLE, arr_rst=0, all other outputs 0, all counters 0.
- IDLE: arr_rst=1, t_ready=0, q_ready=0.
  - start with q_len in 1..N_PE: latch q_len and the cfg_* inputs onto the arr_* outputs, then go to CLEAR.
  - start with q_len=0 or q_len>N_PE: err=1, err_code=1, stay in IDLE.
- CLEAR: arr_rst=0 for exactly 2 cycles, then go to LOAD_Q.
- LOAD_Q: q_ready=1.
  - Each accepted base drives pe_q_we=1, pe_q_idx=count, pe_q_base=q_base on the next cycle.
  - After q_len bases, drop q_ready and go to STREAM.
  - PEs with index >= q_len are never written; they pass data and scores through.
- STREAM: t_ready=1.
  - Each cycle: arr_en <= t_valid; arr_data <= t_base. Latency from input to array is 1 cycle.
  - Accepted t_last: next state is DRAIN and arr_en falls one cycle after the last base.
  - t_valid=0 before t_last is seen: abort. err=1, err_code=2, go to CLEAR (array scrubbed), then IDLE. The PEs cannot stall, so a bubble is illegal.
- DRAIN: arr_en=0, t_ready=0, drain counter increments every cycle.
  - arr_vld=1: score <= arr_high - ZERO (if arr_high < ZERO, score = 0), then go to DONE.
  - Counter reaches DRAIN_MAX without arr_vld: err=1, err_code=3, go to CLEAR, then IDLE.
- DONE: score_valid=1 for one cycle, then IDLE. The next job's CLEAR resets the array.
- start outside IDLE is ignored (no queueing).
- The abort-path CLEAR returns to IDLE, not LOAD_Q; a 1-bit flag selects the path.
- Asynchronous reset mid-job: return immediately to reset values; no score_valid and no err.
- Same-cycle precedence in DRAIN: arr_vld wins over timeout.
- Same-cycle precedence in STREAM: t_last with t_valid=1 is a normal end, never a gap.

Decomposition:
- Shared package sw_pkg: base encodings A/G/T/C, function ZERO(SCORE_WIDTH), err_code constants, state enum (IDLE, CLEAR, LOAD_Q, STREAM, DRAIN, DONE).
- No sub-module. Counters and the FSM live in one module; the array itself is instantiated by the parent.

Test Plan:
- Legal job: q_len=4, query AGTC, target AGTC with t_last on C, cfg match=2, mismatch=-1 (0xFFF), array model returns arr_high=ZERO+8 -> 2 arr_rst low cycles, 4 pe_q_we pulses with idx 0..3, arr_en high exactly 4 cycles, score=8, one score_valid pulse, busy falls after DONE.
- Bad length: start with q_len=0, then with q_len=9 (N_PE=8) -> err pulse with err_code=1 each time, busy stays 0, arr_rst never pulses.
- Stream gap: t_valid low after 2 of 5 target bases -> err_code=2, arr_rst low 2 cycles, back to IDLE, no score_valid.
- Drain timeout: model never asserts arr_vld -> err_code=3 exactly DRAIN_MAX=20 cycles after DRAIN entry, then CLEAR, then IDLE.
- Asynchronous reset mid-STREAM: drop rst between clock edges -> all outputs at reset values before the next edge; after release, a normal job completes with the correct score.
- Config stability and ignored start: change cfg_* inputs and pulse start during STREAM -> arr_* outputs unchanged, no new job launched.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array sequencer: base codes,
// error codes, controller states and the biased-zero helper.
package sw_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_G = 2'b01,
        BASE_T = 2'b10,
        BASE_C = 2'b11
    } base_e;

    localparam logic [1:0] ERR_QLEN    = 2'd1;
    localparam logic [1:0] ERR_GAP     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_Q = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Scores inside the array are stored with this bias so that zero sits mid-range.
    function automatic int unsigned zero_of(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman systolic array: clear, query load,
// gap-free target stream, drain, and unbiased score return.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int N_PE        = 8,
    parameter int SCORE_WIDTH = 12,
    parameter int QLEN_W      = $clog2(N_PE + 1),
    parameter int DRAIN_MAX   = 2 * N_PE + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [QLEN_W-1:0]        q_len,
    input  logic [SCORE_WIDTH-1:0]   cfg_match,
    input  logic [SCORE_WIDTH-1:0]   cfg_mismatch,
    input  logic [SCORE_WIDTH-1:0]   cfg_gap_open,
    input  logic [SCORE_WIDTH-1:0]   cfg_gap_extend,
    input  logic                     q_valid,
    input  logic [1:0]               q_base,
    output logic                     q_ready,
    input  logic                     t_valid,
    input  logic [1:0]               t_base,
    input  logic                     t_last,
    output logic                     t_ready,
    output logic                     arr_rst,
    output logic                     pe_q_we,
    output logic [$clog2(N_PE)-1:0]  pe_q_idx,
    output logic [1:0]               pe_q_base,
    output logic [SCORE_WIDTH-1:0]   arr_match,
    output logic [SCORE_WIDTH-1:0]   arr_mismatch,
    output logic [SCORE_WIDTH-1:0]   arr_gap_open,
    output logic [SCORE_WIDTH-1:0]   arr_gap_extend,
    output logic                     arr_en,
    output logic [1:0]               arr_data,
    input  logic [SCORE_WIDTH-1:0]   arr_high,
    input  logic                     arr_vld,
    output logic                     busy,
    output logic [SCORE_WIDTH-2:0]   score,
    output logic                     score_valid,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int IDX_W = $clog2(N_PE);
    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    localparam logic [QLEN_W-1:0] QMAX       = QLEN_W'(N_PE);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               abort, abort_nxt;
    logic [QLEN_W-1:0]  q_len_r;
    logic [CNT_W-1:0]   q_len_ext;

    logic               err_nxt;
    logic [1:0]         err_code_nxt;
    logic               launch;
    logic               q_acc;
    logic               score_ld;
    logic [SCORE_WIDTH-2:0] score_nxt;

    assign q_len_ext = CNT_W'(q_len_r);

    // Removing a bias of 2**(W-1) is just dropping the MSB; a clear MSB means
    // the biased value is below zero, which clamps to 0.
    assign score_nxt = arr_high[SCORE_WIDTH-1] ? arr_high[SCORE_WIDTH-2:0] : '0;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_ONE;
        abort_nxt    = abort;
        err_nxt      = 1'b0;
        err_code_nxt = err_code;
        launch       = 1'b0;
        q_acc        = 1'b0;
        score_ld     = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    if (q_len == '0 || q_len > QMAX) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_QLEN;
                    end else begin
                        launch    = 1'b1;
                        abort_nxt = 1'b0;
                        state_nxt = CLEAR;
                    end
                end
            end

            CLEAR: begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt   = '0;
                    abort_nxt = 1'b0;
                    state_nxt = abort ? IDLE : LOAD_Q;
                end
            end

            LOAD_Q: begin
                cnt_nxt = cnt;
                if (q_valid) begin
                    q_acc   = 1'b1;
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt + CNT_ONE == q_len_ext) begin
                        cnt_nxt   = '0;
                        state_nxt = STREAM;
                    end
                end
            end

            STREAM: begin
                cnt_nxt = '0;
                // The PEs advance every cycle, so any bubble corrupts the wavefront.
                if (t_valid) begin
                    if (t_last) state_nxt = DRAIN;
                end else begin
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_GAP;
                    abort_nxt    = 1'b1;
                    state_nxt    = CLEAR;
                end
            end

            DRAIN: begin
                if (arr_vld) begin
                    score_ld  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (cnt == DRAIN_LAST) begin
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    abort_nxt    = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = CLEAR;
                end
            end

            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            abort          <= 1'b0;
            q_len_r        <= '0;
            busy           <= 1'b0;
            arr_rst        <= 1'b0;
            q_ready        <= 1'b0;
            t_ready        <= 1'b0;
            pe_q_we        <= 1'b0;
            pe_q_idx       <= '0;
            pe_q_base      <= '0;
            arr_match      <= '0;
            arr_mismatch   <= '0;
            arr_gap_open   <= '0;
            arr_gap_extend <= '0;
            arr_en         <= 1'b0;
            arr_data       <= '0;
            score          <= '0;
            score_valid    <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            abort   <= abort_nxt;

            // Handshake and status outputs follow the state being entered.
            busy    <= (state_nxt != IDLE);
            arr_rst <= (state_nxt != CLEAR);
            q_ready <= (state_nxt == LOAD_Q);
            t_ready <= (state_nxt == STREAM);

            if (launch) begin
                q_len_r        <= q_len;
                arr_match      <= cfg_match;
                arr_mismatch   <= cfg_mismatch;
                arr_gap_open   <= cfg_gap_open;
                arr_gap_extend <= cfg_gap_extend;
            end

            pe_q_we <= q_acc;
            if (q_acc) begin
                pe_q_idx  <= cnt[IDX_W-1:0];
                pe_q_base <= q_base;
            end

            arr_en <= (state == STREAM) && t_valid;
            if (state == STREAM) arr_data <= t_base;

            score_valid <= score_ld;
            if (score_ld) score <= score_nxt;

            err      <= err_nxt;
            err_code <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl: legal jobs, bad length, stream gap,
// drain timeout, async reset mid-job, config stability and score clamping.
module tb_sw_array_ctrl;

    localparam int N_PE = 8;
    localparam int SW   = 12;
    localparam int QW   = $clog2(N_PE + 1);
    localparam int IW   = $clog2(N_PE);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [QW-1:0] q_len = '0;
    logic [SW-1:0] cfg_match = '0, cfg_mismatch = '0, cfg_gap_open = '0, cfg_gap_extend = '0;
    logic          q_valid = 1'b0;
    logic [1:0]    q_base = '0;
    logic          q_ready;
    logic          t_valid = 1'b0;
    logic [1:0]    t_base = '0;
    logic          t_last = 1'b0;
    logic          t_ready;
    logic          arr_rst;
    logic          pe_q_we;
    logic [IW-1:0] pe_q_idx;
    logic [1:0]    pe_q_base;
    logic [SW-1:0] arr_match, arr_mismatch, arr_gap_open, arr_gap_extend;
    logic          arr_en;
    logic [1:0]    arr_data;
    logic [SW-1:0] arr_high = '0;
    logic          arr_vld = 1'b0;
    logic          busy;
    logic [SW-2:0] score;
    logic          score_valid;
    logic          err;
    logic [1:0]    err_code;

    sw_array_ctrl #(.N_PE(N_PE), .SCORE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .q_len(q_len),
        .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
        .cfg_gap_open(cfg_gap_open), .cfg_gap_extend(cfg_gap_extend),
        .q_valid(q_valid), .q_base(q_base), .q_ready(q_ready),
        .t_valid(t_valid), .t_base(t_base), .t_last(t_last), .t_ready(t_ready),
        .arr_rst(arr_rst), .pe_q_we(pe_q_we), .pe_q_idx(pe_q_idx), .pe_q_base(pe_q_base),
        .arr_match(arr_match), .arr_mismatch(arr_mismatch),
        .arr_gap_open(arr_gap_open), .arr_gap_extend(arr_gap_extend),
        .arr_en(arr_en), .arr_data(arr_data), .arr_high(arr_high), .arr_vld(arr_vld),
        .busy(busy), .score(score), .score_valid(score_valid),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Free-running event counters; scenarios compare deltas.
    int rst_low_n = 0, we_n = 0, en_n = 0, sv_n = 0, err_n = 0;
    always @(negedge clk) begin
        if (!arr_rst)    rst_low_n++;
        if (pe_q_we)     we_n++;
        if (arr_en)      en_n++;
        if (score_valid) sv_n++;
        if (err)         err_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [QW-1:0] len);
        q_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_query(input int len, input logic [15:0] bases);
        int n = 0;
        while (!q_ready && n < 10) begin
            tick();
            n++;
        end
        chk("q_ready_wait", 32'(q_ready), 32'd1);
        for (int i = 0; i < len; i++) begin
            q_valid = 1'b1;
            q_base  = bases[2*i +: 2];
            tick();
            chk("pe_q_we", 32'(pe_q_we), 32'd1);
            chk("pe_q_idx", 32'(pe_q_idx), 32'(i));
            chk("pe_q_base", 32'(pe_q_base), 32'(bases[2*i +: 2]));
            if (i == len - 1) begin
                chk("q_ready_drop", 32'(q_ready), 32'd0);
                chk("t_ready_rise", 32'(t_ready), 32'd1);
            end else begin
                chk("q_ready_hold", 32'(q_ready), 32'd1);
            end
        end
        q_valid = 1'b0;
    endtask

    task automatic stream_target(input int len, input logic [15:0] bases);
        for (int i = 0; i < len; i++) begin
            t_valid = 1'b1;
            t_base  = bases[2*i +: 2];
            t_last  = (i == len - 1);
            tick();
            chk("arr_en", 32'(arr_en), 32'd1);
            chk("arr_data", 32'(arr_data), 32'(bases[2*i +: 2]));
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
        chk("t_ready_drain", 32'(t_ready), 32'd0);
    endtask

    task automatic finish_drain(input logic [SW-1:0] high, input int delay, input logic [SW-2:0] exp_score);
        repeat (delay) tick();
        arr_high = high;
        arr_vld  = 1'b1;
        tick();
        arr_vld  = 1'b0;
        chk("score_valid_pulse", 32'(score_valid), 32'd1);
        chk("score", 32'(score), 32'(exp_score));
        chk("busy_done", 32'(busy), 32'd1);
        tick();
        chk("score_valid_low", 32'(score_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("score_hold", 32'(score), 32'(exp_score));
    endtask

    initial begin
        int b_rst, b_we, b_en, b_sv, b_err, n;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arr_rst", 32'(arr_rst), 32'd0);
        chk("rst_q_ready", 32'(q_ready), 32'd0);
        chk("rst_t_ready", 32'(t_ready), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_score_valid", 32'(score_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_arr_rst", 32'(arr_rst), 32'd1);

        // Legal job: query AGTC, target AGTC, biased high ZERO+8
        b_rst = rst_low_n; b_we = we_n; b_en = en_n; b_sv = sv_n; b_err = err_n;
        cfg_match = 12'h002; cfg_mismatch = 12'hFFF; cfg_gap_open = 12'hFFD; cfg_gap_extend = 12'hFFF;
        launch(4'd4);
        chk("j1_busy", 32'(busy), 32'd1);
        chk("j1_arr_rst", 32'(arr_rst), 32'd0);
        chk("j1_arr_match", 32'(arr_match), 32'h002);
        chk("j1_arr_mismatch", 32'(arr_mismatch), 32'hFFF);
        load_query(4, 16'h00E4);
        chk("j1_clear_cycles", 32'(rst_low_n - b_rst), 32'd2);
        stream_target(4, 16'h00E4);
        tick();
        chk("j1_arr_en_fall", 32'(arr_en), 32'd0);
        finish_drain(12'h808, 3, 11'd8);
        chk("j1_we_pulses", 32'(we_n - b_we), 32'd4);
        chk("j1_en_cycles", 32'(en_n - b_en), 32'd4);
        chk("j1_sv_pulses", 32'(sv_n - b_sv), 32'd1);
        chk("j1_no_err", 32'(err_n - b_err), 32'd0);

        // Bad length: 0 and N_PE+1
        b_rst = rst_low_n; b_err = err_n;
        launch(4'd0);
        chk("bl0_err", 32'(err), 32'd1);
        chk("bl0_code", 32'(err_code), 32'd1);
        chk("bl0_busy", 32'(busy), 32'd0);
        tick();
        chk("bl0_err_pulse", 32'(err), 32'd0);
        chk("bl0_code_hold", 32'(err_code), 32'd1);
        launch(4'd9);
        chk("bl9_err", 32'(err), 32'd1);
        chk("bl9_code", 32'(err_code), 32'd1);
        chk("bl9_busy", 32'(busy), 32'd0);
        tick();
        chk("bl_no_clear", 32'(rst_low_n - b_rst), 32'd0);
        chk("bl_err_pulses", 32'(err_n - b_err), 32'd2);

        // Stream gap after 2 of 5 bases
        launch(4'd2);
        load_query(2, 16'h0004);
        b_rst = rst_low_n; b_sv = sv_n;
        for (int i = 0; i < 2; i++) begin
            t_valid = 1'b1;
            t_base  = 2'(i + 1);
            tick();
            chk("gap_arr_en", 32'(arr_en), 32'd1);
        end
        t_valid = 1'b0;
        tick();
        chk("gap_err", 32'(err), 32'd1);
        chk("gap_code", 32'(err_code), 32'd2);
        chk("gap_arr_rst", 32'(arr_rst), 32'd0);
        chk("gap_t_ready", 32'(t_ready), 32'd0);
        chk("gap_arr_en_off", 32'(arr_en), 32'd0);
        tick();
        chk("gap_clear2", 32'(arr_rst), 32'd0);
        chk("gap_err_pulse", 32'(err), 32'd0);
        tick();
        chk("gap_idle_arr_rst", 32'(arr_rst), 32'd1);
        chk("gap_idle_busy", 32'(busy), 32'd0);
        chk("gap_no_load", 32'(q_ready), 32'd0);
        chk("gap_clear_cycles", 32'(rst_low_n - b_rst), 32'd2);
        chk("gap_no_score", 32'(sv_n - b_sv), 32'd0);

        // Drain timeout: arr_vld never rises
        launch(4'd1);
        load_query(1, 16'h0003);
        stream_target(1, 16'h0002);
        b_sv = sv_n;
        n = 0;
        while (!err && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd20);
        chk("to_code", 32'(err_code), 32'd3);
        chk("to_arr_rst", 32'(arr_rst), 32'd0);
        tick();
        chk("to_clear2", 32'(arr_rst), 32'd0);
        tick();
        chk("to_idle_arr_rst", 32'(arr_rst), 32'd1);
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_no_score", 32'(sv_n - b_sv), 32'd0);

        // Asynchronous reset in the middle of STREAM
        launch(4'd2);
        load_query(2, 16'h0009);
        t_valid = 1'b1;
        t_base  = 2'b01;
        tick();
        b_sv = sv_n; b_err = err_n;
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_t_ready", 32'(t_ready), 32'd0);
        chk("ar_arr_en", 32'(arr_en), 32'd0);
        chk("ar_arr_rst", 32'(arr_rst), 32'd0);
        chk("ar_score", 32'(score), 32'd0);
        chk("ar_err_code", 32'(err_code), 32'd0);
        chk("ar_arr_match", 32'(arr_match), 32'd0);
        t_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("ar_release_arr_rst", 32'(arr_rst), 32'd1);
        chk("ar_no_sv", 32'(sv_n - b_sv), 32'd0);
        chk("ar_no_err", 32'(err_n - b_err), 32'd0);

        // Post-reset job; cfg changes and start during STREAM are ignored
        cfg_match = 12'h003; cfg_mismatch = 12'hFFE; cfg_gap_open = 12'hFFC; cfg_gap_extend = 12'hFFF;
        launch(4'd3);
        load_query(3, 16'h0024);
        cfg_match = 12'h007; cfg_mismatch = 12'h001; cfg_gap_open = 12'h005; cfg_gap_extend = 12'h006;
        q_len = 4'd1;
        start = 1'b1;
        stream_target(3, 16'h0024);
        start = 1'b0;
        chk("cs_arr_match", 32'(arr_match), 32'h003);
        chk("cs_arr_mismatch", 32'(arr_mismatch), 32'hFFE);
        chk("cs_arr_gap_open", 32'(arr_gap_open), 32'hFFC);
        chk("cs_arr_gap_extend", 32'(arr_gap_extend), 32'hFFF);
        tick();
        chk("cs_arr_en_fall", 32'(arr_en), 32'd0);
        finish_drain(12'h805, 5, 11'd5);
        b_rst = rst_low_n;
        tick();
        chk("cs_no_relaunch", 32'(busy), 32'd0);
        chk("cs_no_clear", 32'(rst_low_n - b_rst), 32'd0);

        // Biased score below zero clamps to 0
        launch(4'd1);
        load_query(1, 16'h0001);
        stream_target(1, 16'h0000);
        tick();
        finish_drain(12'h7FF, 2, 11'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
